// File: rtl/iob_iob2axi_wr_burst.sv
// Native-to-AXI4 write DMA master: prefetches native words into a 2-entry FIFO and
// writes them as INCR bursts. Define IOB_IOB2AXI_WR_4K_EN to stop bursts at 4 KB boundaries.
module iob_iob2axi_wr_burst #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int AXI_ID_W  = 1,
    parameter int AXI_LEN_W = 8,
    parameter int MAX_BURST = 16,
    parameter int TOTAL_W   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  run_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [TOTAL_W-1:0]    nbeats_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic                  error_o,

    output logic                  m_valid_o,
    output logic [ADDR_W-1:0]     m_addr_o,
    input  logic [DATA_W-1:0]     m_rdata_i,
    input  logic                  m_ready_i,

    output logic [AXI_ID_W-1:0]   m_axi_awid_o,
    output logic [ADDR_W-1:0]     m_axi_awaddr_o,
    output logic [AXI_LEN_W-1:0]  m_axi_awlen_o,
    output logic [2:0]            m_axi_awsize_o,
    output logic [1:0]            m_axi_awburst_o,
    output logic [1:0]            m_axi_awlock_o,
    output logic [3:0]            m_axi_awcache_o,
    output logic [2:0]            m_axi_awprot_o,
    output logic [3:0]            m_axi_awqos_o,
    output logic                  m_axi_awvalid_o,
    input  logic                  m_axi_awready_i,

    output logic [DATA_W-1:0]     m_axi_wdata_o,
    output logic [DATA_W/8-1:0]   m_axi_wstrb_o,
    output logic                  m_axi_wlast_o,
    output logic                  m_axi_wvalid_o,
    input  logic                  m_axi_wready_i,

    input  logic [AXI_ID_W-1:0]   m_axi_bid_i,
    input  logic [1:0]            m_axi_bresp_i,
    input  logic                  m_axi_bvalid_i,
    output logic                  m_axi_bready_o
);
    localparam int BSHIFT = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                 state_q;
    logic [ADDR_W-1:0]      start_addr_q;
    logic [ADDR_W-1:0]      awaddr_q;
    logic [TOTAL_W-1:0]     total_q;
    logic [TOTAL_W-1:0]     fetched_q;
    logic [TOTAL_W-1:0]     remaining_q;
    logic [TOTAL_W-1:0]     len_q;
    logic [AXI_LEN_W-1:0]   awlen_q;
    logic [AXI_LEN_W-1:0]   beat_q;
    logic                   awvalid_q;
    logic                   done_q;
    logic                   error_q;

    logic [DATA_W-1:0]      fifo_mem_q [2];
    logic                   wr_ptr_q;
    logic                   rd_ptr_q;
    logic [1:0]             count_q;

    logic                   push;
    logic                   pop;
    logic [ADDR_W-1:0]      addr_d;
    logic [TOTAL_W-1:0]     rem_d;
    logic [TOTAL_W-1:0]     len_start_d;
    logic [TOTAL_W-1:0]     len_next_d;
    logic [31:0]            room_start;
    logic [31:0]            room_next;
    logic                   unused_bid;

    function automatic logic [TOTAL_W-1:0] clip_len(input logic [TOTAL_W-1:0] rem,
                                                    input logic [31:0] room);
        logic [31:0] l;
        l = 32'(rem);
        if (l > 32'(MAX_BURST)) l = 32'(MAX_BURST);
        if (l > room) l = room;
        return TOTAL_W'(l);
    endfunction

`ifdef IOB_IOB2AXI_WR_4K_EN
    // Beats that fit between the address and the next 4 KB page boundary.
    function automatic logic [31:0] room_4k(input logic [ADDR_W-1:0] a);
        logic [12:0] bytes_left;
        bytes_left = 13'h1000 - {1'b0, a[11:0]};
        return 32'(bytes_left >> BSHIFT);
    endfunction

    assign room_start = room_4k(addr_i);
    assign room_next  = room_4k(addr_d);
`else
    assign room_start = 32'(MAX_BURST);
    assign room_next  = 32'(MAX_BURST);
`endif

    assign addr_d      = awaddr_q + (ADDR_W'(len_q) << BSHIFT);
    assign rem_d       = remaining_q - len_q;
    assign len_start_d = clip_len(nbeats_i, room_start);
    assign len_next_d  = clip_len(rem_d, room_next);

    assign ready_o   = (state_q == IDLE);
    assign done_o    = done_q;
    assign error_o   = error_q;
    assign m_valid_o = (state_q != IDLE) && (fetched_q < total_q) && (count_q != 2'd2);
    assign m_addr_o  = start_addr_q + (ADDR_W'(fetched_q) << BSHIFT);

    assign m_axi_awid_o    = '0;
    assign m_axi_awaddr_o  = awaddr_q;
    assign m_axi_awlen_o   = awlen_q;
    assign m_axi_awsize_o  = 3'(BSHIFT);
    assign m_axi_awburst_o = 2'b01;
    assign m_axi_awlock_o  = 2'b00;
    assign m_axi_awcache_o = 4'd2;
    assign m_axi_awprot_o  = 3'd2;
    assign m_axi_awqos_o   = 4'd0;
    assign m_axi_awvalid_o = awvalid_q;

    assign m_axi_wvalid_o = (state_q == DATA) && (count_q != 2'd0);
    assign m_axi_wdata_o  = fifo_mem_q[rd_ptr_q];
    assign m_axi_wstrb_o  = '1;
    assign m_axi_wlast_o  = m_axi_wvalid_o && (beat_q == awlen_q);
    assign m_axi_bready_o = (state_q == RESP);

    assign push       = m_valid_o && m_ready_i;
    assign pop        = m_axi_wvalid_o && m_axi_wready_i;
    assign unused_bid = ^m_axi_bid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem_q[wr_ptr_q] <= m_rdata_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            start_addr_q <= '0;
            awaddr_q     <= '0;
            total_q      <= '0;
            fetched_q    <= '0;
            remaining_q  <= '0;
            len_q        <= '0;
            awlen_q      <= '0;
            beat_q       <= '0;
            awvalid_q    <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (push) fetched_q <= fetched_q + TOTAL_W'(1);
            case (state_q)
                IDLE: begin
                    if (run_i && (nbeats_i != '0)) begin
                        start_addr_q <= addr_i;
                        total_q      <= nbeats_i;
                        fetched_q    <= '0;
                        awaddr_q     <= addr_i;
                        remaining_q  <= nbeats_i;
                        len_q        <= len_start_d;
                        awlen_q      <= AXI_LEN_W'(len_start_d - TOTAL_W'(1));
                        awvalid_q    <= 1'b1;
                        error_q      <= 1'b0;
                        state_q      <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_axi_awready_i) begin
                        awvalid_q <= 1'b0;
                        beat_q    <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (pop) begin
                        beat_q <= beat_q + AXI_LEN_W'(1);
                        if (m_axi_wlast_o) state_q <= RESP;
                    end
                end
                RESP: begin
                    if (m_axi_bvalid_i) begin
                        error_q     <= error_q | (|m_axi_bresp_i);
                        awaddr_q    <= addr_d;
                        remaining_q <= rem_d;
                        if (rem_d != '0) begin
                            len_q     <= len_next_d;
                            awlen_q   <= AXI_LEN_W'(len_next_d - TOTAL_W'(1));
                            awvalid_q <= 1'b1;
                            state_q   <= ADDR;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iob_iob2axi_wr_burst.sv
// Self-checking bench for iob_iob2axi_wr_burst: directed vector table, random transfers
// with back-pressure, reset and zero-length corner cases, all against a burst-list model.
`timescale 1ns/1ps
module tb_iob_iob2axi_wr_burst;
    localparam int ADDR_W = 32, DATA_W = 32, AXI_ID_W = 1, AXI_LEN_W = 8;
    localparam int MAX_BURST = 16, TOTAL_W = 16;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;

    logic                 run_i;
    logic [ADDR_W-1:0]    addr_i;
    logic [TOTAL_W-1:0]   nbeats_i;
    logic                 ready_o, done_o, error_o;
    logic                 m_valid_o;
    logic [ADDR_W-1:0]    m_addr_o;
    logic [DATA_W-1:0]    m_rdata_i;
    logic                 m_ready_i;
    logic [AXI_ID_W-1:0]  m_axi_awid_o;
    logic [ADDR_W-1:0]    m_axi_awaddr_o;
    logic [AXI_LEN_W-1:0] m_axi_awlen_o;
    logic [2:0]           m_axi_awsize_o;
    logic [1:0]           m_axi_awburst_o, m_axi_awlock_o;
    logic [3:0]           m_axi_awcache_o, m_axi_awqos_o;
    logic [2:0]           m_axi_awprot_o;
    logic                 m_axi_awvalid_o, m_axi_awready_i;
    logic [DATA_W-1:0]    m_axi_wdata_o;
    logic [DATA_W/8-1:0]  m_axi_wstrb_o;
    logic                 m_axi_wlast_o, m_axi_wvalid_o, m_axi_wready_i;
    logic [AXI_ID_W-1:0]  m_axi_bid_i;
    logic [1:0]           m_axi_bresp_i;
    logic                 m_axi_bvalid_i, m_axi_bready_o;

    iob_iob2axi_wr_burst #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AXI_ID_W(AXI_ID_W), .AXI_LEN_W(AXI_LEN_W),
        .MAX_BURST(MAX_BURST), .TOTAL_W(TOTAL_W)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .run_i(run_i), .addr_i(addr_i), .nbeats_i(nbeats_i),
        .ready_o(ready_o), .done_o(done_o), .error_o(error_o),
        .m_valid_o(m_valid_o), .m_addr_o(m_addr_o), .m_rdata_i(m_rdata_i), .m_ready_i(m_ready_i),
        .m_axi_awid_o(m_axi_awid_o), .m_axi_awaddr_o(m_axi_awaddr_o), .m_axi_awlen_o(m_axi_awlen_o),
        .m_axi_awsize_o(m_axi_awsize_o), .m_axi_awburst_o(m_axi_awburst_o),
        .m_axi_awlock_o(m_axi_awlock_o), .m_axi_awcache_o(m_axi_awcache_o),
        .m_axi_awprot_o(m_axi_awprot_o), .m_axi_awqos_o(m_axi_awqos_o),
        .m_axi_awvalid_o(m_axi_awvalid_o), .m_axi_awready_i(m_axi_awready_i),
        .m_axi_wdata_o(m_axi_wdata_o), .m_axi_wstrb_o(m_axi_wstrb_o),
        .m_axi_wlast_o(m_axi_wlast_o), .m_axi_wvalid_o(m_axi_wvalid_o),
        .m_axi_wready_i(m_axi_wready_i),
        .m_axi_bid_i(m_axi_bid_i), .m_axi_bresp_i(m_axi_bresp_i),
        .m_axi_bvalid_i(m_axi_bvalid_i), .m_axi_bready_o(m_axi_bready_o)
    );

    // Native memory: every word is a distinct function of its byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[17:2]};
    endfunction
    assign m_rdata_i = mem_word(m_addr_o);

    int checks = 0;
    int errors = 0;

    function automatic void chk(input bit ok, input string name,
                                input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Expected transaction streams produced by the model.
    logic [31:0] exp_aw_addr[$];
    logic [7:0]  exp_aw_len[$];
    logic [31:0] exp_data[$];
    bit          exp_last[$];
    int          exp_beats;

    bit   mon_en = 1'b0;
    bit   bp_mode = 1'b0;
    int   err_burst = -1;
    int   b_idx = 0;
    int   pending_b = 0;
    bit   b_hs = 1'b0;
    int   cyc = 0;
    int   b_cyc = -10;
    int   aw_seen, w_seen, done_seen, occ;
    int   stab_err, fifo_err, order_err, lat_err;
    bit   aw_ok, aw_stall, aw_prev_valid;
    logic [31:0] aw_prev_addr;
    logic [7:0]  aw_prev_len;
    logic        err_at_done;

    always @(posedge clk) cyc <= cyc + 1;

    // AXI slave and native-port responder; inputs change 1 ns after each rising edge.
    initial begin
        m_axi_awready_i = 1'b0; m_axi_wready_i = 1'b0; m_ready_i = 1'b0;
        m_axi_bvalid_i = 1'b0; m_axi_bresp_i = 2'b00; m_axi_bid_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_i) begin
                m_axi_bvalid_i = 1'b0;
                b_hs = 1'b0;
                pending_b = 0;
            end else begin
                m_axi_awready_i = bp_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
                m_axi_wready_i  = bp_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
                m_ready_i       = bp_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (b_hs) begin
                    m_axi_bvalid_i = 1'b0;
                    b_hs = 1'b0;
                end
                if (!m_axi_bvalid_i && pending_b > 0 && (!bp_mode || $urandom_range(0, 1) == 1)) begin
                    m_axi_bvalid_i = 1'b1;
                    m_axi_bresp_i  = (b_idx == err_burst) ? 2'b10 : 2'b00;
                    b_idx++;
                    pending_b--;
                end
            end
        end
    end

    // Monitor: at the falling edge, valid/ready are stable for the coming rising edge.
    always @(negedge clk) begin
        if (mon_en && !rst_i) begin
            if (aw_stall && !(m_axi_awvalid_o && m_axi_awaddr_o == aw_prev_addr &&
                              m_axi_awlen_o == aw_prev_len))
                stab_err++;
            if (m_axi_awvalid_o && !aw_prev_valid && aw_seen > 0 && cyc != b_cyc + 1)
                lat_err++;
            aw_prev_valid = m_axi_awvalid_o;
            aw_stall      = m_axi_awvalid_o && !m_axi_awready_i;
            aw_prev_addr  = m_axi_awaddr_o;
            aw_prev_len   = m_axi_awlen_o;
            if (m_axi_wvalid_o) begin
                if (!aw_ok) order_err++;
                if (occ == 0) fifo_err++;
            end
            if (m_axi_awvalid_o && m_axi_awready_i) begin
                if (exp_aw_addr.size() == 0) begin
                    chk(1'b0, "unexpected AW", 64'(m_axi_awaddr_o), 64'(0));
                end else begin
                    logic [31:0] ea;
                    logic [7:0]  el;
                    ea = exp_aw_addr.pop_front();
                    el = exp_aw_len.pop_front();
                    chk(m_axi_awaddr_o == ea, "awaddr", 64'(m_axi_awaddr_o), 64'(ea));
                    chk(m_axi_awlen_o == el, "awlen", 64'(m_axi_awlen_o), 64'(el));
                end
                aw_seen++;
                aw_ok = 1'b1;
            end
            if (m_axi_wvalid_o && m_axi_wready_i) begin
                if (exp_data.size() == 0) begin
                    chk(1'b0, "unexpected W", 64'(m_axi_wdata_o), 64'(0));
                end else begin
                    logic [31:0] ed;
                    bit          elast;
                    ed    = exp_data.pop_front();
                    elast = exp_last.pop_front();
                    chk(m_axi_wdata_o == ed, "wdata", 64'(m_axi_wdata_o), 64'(ed));
                    chk(m_axi_wlast_o == elast, "wlast", 64'(m_axi_wlast_o), 64'(elast));
                end
                w_seen++;
                if (m_axi_wlast_o) begin
                    pending_b++;
                    aw_ok = 1'b0;
                end
                occ--;
            end
            if (m_valid_o && m_ready_i) occ++;
            if (occ > 2 || occ < 0) fifo_err++;
            if (m_axi_bvalid_i && m_axi_bready_o) begin
                b_hs  = 1'b1;
                b_cyc = cyc;
            end
            if (done_o) begin
                done_seen++;
                err_at_done = error_o;
                if (cyc != b_cyc + 1 || !ready_o) lat_err++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Model: burst list and beat stream from the splitting rules, then issue run_i.
    task automatic start_xfer(input logic [31:0] a, input logic [15:0] n, input bit bp,
                              input int errb, output int nb);
        int rem;
        int l;
        logic [31:0] cur;
        exp_aw_addr.delete(); exp_aw_len.delete(); exp_data.delete(); exp_last.delete();
        rem = int'(n); cur = a; nb = 0; exp_beats = int'(n);
        while (rem > 0) begin
            l = (rem < MAX_BURST) ? rem : MAX_BURST;
`ifdef IOB_IOB2AXI_WR_4K_EN
            begin
                int room;
                room = (4096 - int'(cur % 4096)) / 4;
                if (room < l) l = room;
            end
`endif
            exp_aw_addr.push_back(cur);
            exp_aw_len.push_back(8'(l - 1));
            for (int i = 0; i < l; i++) begin
                exp_data.push_back(mem_word(cur + 32'(i * 4)));
                exp_last.push_back(i == l - 1);
            end
            cur = cur + 32'(l * 4);
            rem -= l;
            nb++;
        end
        bp_mode = bp; err_burst = errb; b_idx = 0;
        aw_seen = 0; w_seen = 0; done_seen = 0; occ = 0;
        stab_err = 0; fifo_err = 0; order_err = 0; lat_err = 0;
        aw_ok = 1'b0; aw_stall = 1'b0; aw_prev_valid = 1'b0; err_at_done = 1'b0;
        mon_en = 1'b1;
        chk(ready_o == 1'b1, "ready before run", 64'(ready_o), 64'(1));
        run_i = 1'b1; addr_i = a; nbeats_i = n;
        tick();
        run_i = 1'b0;
        chk(ready_o == 1'b0, "start ready", 64'(ready_o), 64'(0));
        chk(m_axi_awvalid_o == 1'b1, "start awvalid", 64'(m_axi_awvalid_o), 64'(1));
        chk(error_o == 1'b0, "start error clear", 64'(error_o), 64'(0));
    endtask

    task automatic finish_xfer(input int exp_aws, input logic exp_err, input string tag);
        int budget;
        budget = 0;
        while (done_seen == 0 && budget < 3000) begin
            tick();
            budget++;
        end
        chk(done_seen != 0, {tag, " done timeout"}, 64'(done_seen), 64'(1));
        repeat (3) tick();
        chk(done_seen == 1, {tag, " done count"}, 64'(done_seen), 64'(1));
        chk(aw_seen == exp_aws, {tag, " AW count"}, 64'(aw_seen), 64'(exp_aws));
        chk(w_seen == exp_beats, {tag, " W count"}, 64'(w_seen), 64'(exp_beats));
        chk(err_at_done == exp_err, {tag, " error at done"}, 64'(err_at_done), 64'(exp_err));
        chk(lat_err == 0, {tag, " done/gap timing"}, 64'(lat_err), 64'(0));
        chk(stab_err == 0, {tag, " AW stability"}, 64'(stab_err), 64'(0));
        chk(fifo_err == 0, {tag, " FIFO occupancy"}, 64'(fifo_err), 64'(0));
        chk(order_err == 0, {tag, " W before AW"}, 64'(order_err), 64'(0));
        chk(ready_o == 1'b1, {tag, " ready after"}, 64'(ready_o), 64'(1));
        $display("xfer %s: aws=%0d beats=%0d err=%0b", tag, aw_seen, w_seen, err_at_done);
    endtask

    task automatic check_reset_vals(input string tag);
        chk(ready_o == 1'b1, {tag, " ready"}, 64'(ready_o), 64'(1));
        chk(done_o == 1'b0, {tag, " done"}, 64'(done_o), 64'(0));
        chk(error_o == 1'b0, {tag, " error"}, 64'(error_o), 64'(0));
        chk(m_valid_o == 1'b0, {tag, " m_valid"}, 64'(m_valid_o), 64'(0));
        chk(m_axi_awvalid_o == 1'b0, {tag, " awvalid"}, 64'(m_axi_awvalid_o), 64'(0));
        chk(m_axi_wvalid_o == 1'b0, {tag, " wvalid"}, 64'(m_axi_wvalid_o), 64'(0));
        chk(m_axi_wlast_o == 1'b0, {tag, " wlast"}, 64'(m_axi_wlast_o), 64'(0));
        chk(m_axi_bready_o == 1'b0, {tag, " bready"}, 64'(m_axi_bready_o), 64'(0));
        chk(m_axi_awaddr_o == '0, {tag, " awaddr"}, 64'(m_axi_awaddr_o), 64'(0));
        chk(m_axi_awlen_o == '0, {tag, " awlen"}, 64'(m_axi_awlen_o), 64'(0));
        chk(m_addr_o == '0, {tag, " m_addr"}, 64'(m_addr_o), 64'(0));
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [15:0] nbeats;
        bit          bp;
        int          errb;
        int          exp_aws;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int nb;
        int budget;
        vecs[0] = '{32'h0000_1000, 16'd16, 1'b0, -1, 1, 1'b0};
        vecs[1] = '{32'h0000_0000, 16'd40, 1'b0, -1, 3, 1'b0};
`ifdef IOB_IOB2AXI_WR_4K_EN
        vecs[2] = '{32'h0000_0FF8, 16'd8,  1'b0, -1, 2, 1'b0};
`else
        vecs[2] = '{32'h0000_0FF8, 16'd8,  1'b0, -1, 1, 1'b0};
`endif
        vecs[3] = '{32'h0000_0100, 16'd48, 1'b0,  1, 3, 1'b1};
        vecs[4] = '{32'h0000_3000, 16'd37, 1'b1, -1, 3, 1'b0};

        run_i = 1'b0; addr_i = '0; nbeats_i = '0;
        rst_i = 1'b1;
        repeat (3) tick();
        check_reset_vals("reset");
        rst_i = 1'b0;
        tick();
        chk(ready_o == 1'b1, "idle ready", 64'(ready_o), 64'(1));
        chk(m_axi_awsize_o == 3'd2, "awsize", 64'(m_axi_awsize_o), 64'(2));
        chk(m_axi_awburst_o == 2'b01, "awburst", 64'(m_axi_awburst_o), 64'(1));
        chk(m_axi_wstrb_o == 4'hF, "wstrb", 64'(m_axi_wstrb_o), 64'(15));

        for (int v = 0; v < 5; v++) begin
            start_xfer(vecs[v].addr, vecs[v].nbeats, vecs[v].bp, vecs[v].errb, nb);
            finish_xfer(vecs[v].exp_aws, vecs[v].exp_err, $sformatf("vec%0d", v));
            if (v == 3) chk(error_o == 1'b1, "error sticky", 64'(error_o), 64'(1));
        end

        // Zero-length run must be ignored entirely.
        aw_seen = 0;
        run_i = 1'b1; addr_i = 32'h500; nbeats_i = 16'd0;
        tick();
        run_i = 1'b0;
        chk(ready_o == 1'b1, "zero-len ready", 64'(ready_o), 64'(1));
        chk(m_axi_awvalid_o == 1'b0, "zero-len awvalid", 64'(m_axi_awvalid_o), 64'(0));
        repeat (10) tick();
        chk(aw_seen == 0, "zero-len AW count", 64'(aw_seen), 64'(0));
        $display("xfer zero-len: aws=%0d", aw_seen);

        for (int r = 0; r < 6; r++) begin
            logic [31:0] a;
            logic [15:0] n;
            int          errb;
            a    = 32'($urandom_range(0, 16383)) << 2;
            n    = 16'($urandom_range(1, 50));
            errb = int'($urandom_range(0, 3)) - 1;
            start_xfer(a, n, 1'b1, errb, nb);
            finish_xfer(nb, (errb >= 0 && errb < nb), $sformatf("rand%0d", r));
        end

        // Reset in the middle of a data burst, then a clean transfer.
        start_xfer(32'h400, 16'd32, 1'b0, -1, nb);
        budget = 0;
        while (w_seen < 5 && budget < 200) begin
            tick();
            budget++;
        end
        chk(w_seen >= 5, "mid-data reach", 64'(w_seen), 64'(5));
        mon_en = 1'b0;
        rst_i = 1'b1;
        #1;
        check_reset_vals("midrst");
        exp_aw_addr.delete(); exp_aw_len.delete(); exp_data.delete(); exp_last.delete();
        repeat (2) tick();
        rst_i = 1'b0;
        tick();
        start_xfer(32'h200, 16'd4, 1'b0, -1, nb);
        finish_xfer(1, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
